dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The module SHALL have the input clk (1 bit), the system clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have the input reset (1 bit), asynchronous, active-high.
REQ-003 The module SHALL have the inputs m0_req, m0_we (1 bit each), m0_op (3 bits, DM_op code from const.v), m0_addr and m0_wdata (32 bits each), forming requester 0 (CPU MEM stage).
REQ-004 The module SHALL have the outputs m0_ready (1 bit, access done), m0_err (1 bit, access rejected) and m0_rdata (32 bits) for requester 0.
REQ-005 The module SHALL have the port group m1_req, m1_we, m1_op, m1_addr, m1_wdata, m1_ready, m1_err and m1_rdata, identical to requester 0, forming requester 1 (debug/bridge port).
REQ-006 The module SHALL have the outputs dm_A (32 bits), dm_WD (32 bits), dm_op (3 bits) and dm_wr (1 bit), which drive the shared data memory.
REQ-007 The module SHALL have the input dm_rdata (32 bits), the combinational read data returned by the data memory.

Function
REQ-008 The module SHALL implement an FSM with the states IDLE, SERVE0 and SERVE1.
REQ-009 In IDLE the module SHALL sample m0_req and m1_req at each rising edge.
  - No request: stay in IDLE.
  - One request: go to the SERVE state of that requester.
  - Both requests: apply the arbitration policy in REQ-018.
REQ-010 In SERVEx the module SHALL drive dm_A, dm_WD and dm_op from mx_addr, mx_wdata and mx_op, and assert mx_ready for exactly one cycle.
REQ-011 In SERVEx, dm_wr SHALL equal mx_we when the access is legal, and SHALL be 0 otherwise.
REQ-012 In SERVEx, mx_rdata SHALL equal dm_rdata.
REQ-013 SERVEx SHALL always return to IDLE on the next edge.
  - Latency from req sampled to ready: 1 cycle.
  - Maximum throughput: one access per 2 cycles.
  - A req still high on the edge that ends SERVEx SHALL count as consumed.
REQ-014 A requester SHALL hold its req, we, op, addr and wdata stable from req assertion until its ready; the arbiter does not latch these fields.
REQ-015 In IDLE, and toward the non-served requester, all dm_* outputs SHALL be 0 and all ready/err/rdata outputs SHALL be 0.
REQ-016 An access SHALL be illegal in any of these cases:
  - op = DM_w with addr[1:0] != 0;
  - op = DM_h or DM_hu with addr[0] = 1;
  - we = 1 with op = DM_hu or DM_bu;
  - op is not one of DM_w, DM_h, DM_hu, DM_b, DM_bu.
REQ-017 An illegal access SHALL assert both mx_ready and mx_err in its SERVE cycle, keep dm_wr = 0 and return mx_rdata = 0.
REQ-018 The arbitration policy for simultaneous requests SHALL be selected by the ARB_RR_EN macro (REQ-022).

Reset
REQ-019 While reset is high the FSM SHALL be in IDLE, the last-grant register SHALL be 1, and every output SHALL be 0.
REQ-020 Reset asserted during SERVEx SHALL abort the access immediately.
  - dm_wr drops asynchronously.
  - No ready is issued.
  - After reset release, still-pending requests SHALL be re-arbitrated from IDLE.
REQ-021 The last-grant register SHALL update on every entry to SERVEx, holding the index of the last requester granted.

Configuration
REQ-022 When ARB_RR_EN is defined, simultaneous requests SHALL be granted to the requester not recorded in last-grant (round-robin).
REQ-023 When ARB_RR_EN is undefined, simultaneous requests SHALL always be granted to requester 0 (fixed priority), and the last-grant register SHALL be absent.

Verification
REQ-024 m0 store word:
  - Stimulus: m0 req, we=1, op=DM_w, addr=0x0000_0004, wdata=0xDEADBEEF.
  - Required: next cycle dm_wr=1, dm_A=0x4, dm_WD=0xDEADBEEF, m0_ready=1 for 1 cycle, then IDLE.
REQ-025 m1 signed byte load:
  - Stimulus: m1 req, we=0, op=DM_b, addr=0x0000_0003, with memory word 0x80xx_xxxx.
  - Required: m1_ready=1 with m1_rdata=0xFFFFFF80, dm_wr=0.
REQ-026 Fixed priority (without ARB_RR_EN):
  - Stimulus: m0 and m1 request continuously.
  - Required: grant sequence SERVE0, IDLE, SERVE0, IDLE, ...; m1_ready never asserts.
REQ-027 Round-robin (with ARB_RR_EN):
  - Stimulus: same as REQ-026.
  - Required: grants alternate, with the first grant to m0 after reset (last-grant = 1).
REQ-028 Illegal accesses:
  - Stimulus: m0 op=DM_h, addr=0x1, we=1.
  - Required: m0_ready=1, m0_err=1, dm_wr=0.
  - Stimulus: m1 we=1 with op=DM_bu.
  - Required: m1_err=1.
REQ-029 Reset mid-access:
  - Stimulus: assert reset during SERVE0 of a store.
  - Required: dm_wr=0 immediately, no m0_ready; after release with m0_req held, the store completes exactly once.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester data-memory arbiter with access legality checking.
// Round-robin arbitration when ARB_RR_EN is defined, otherwise fixed priority to requester 0.
module dm_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_op,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_op,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [31:0] dm_A,
    output logic [31:0] dm_WD,
    output logic [2:0]  dm_op,
    output logic        dm_wr,
    input  logic [31:0] dm_rdata
);

    // Data-memory operation codes shared with the CPU datapath.
    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        sel_we;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        legal;

    function automatic logic access_legal(input logic we, input logic [2:0] op,
                                          input logic [1:0] low);
        logic ok;
        case (op)
            DM_W:    ok = (low == 2'b00);
            DM_H:    ok = !low[0];
            DM_HU:   ok = !low[0] && !we;
            DM_B:    ok = 1'b1;
            DM_BU:   ok = !we;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      last_grant <= 1'b1;
        else if (state_q == IDLE && state_d == SERVE0)  last_grant <= 1'b0;
        else if (state_q == IDLE && state_d == SERVE1)  last_grant <= 1'b1;
    end
`endif

    // Requests are only looked at from IDLE, so a req still high at the end of
    // SERVEx has been consumed and is re-arbitrated as a new access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
                    state_d = last_grant ? SERVE0 : SERVE1;
`else
                    state_d = SERVE0;
`endif
                end else if (m0_req) begin
                    state_d = SERVE0;
                end else if (m1_req) begin
                    state_d = SERVE1;
                end
            end
            SERVE0:  state_d = IDLE;
            SERVE1:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = (state_q == SERVE1) ? m1_we    : m0_we;
        sel_op    = (state_q == SERVE1) ? m1_op    : m0_op;
        sel_addr  = (state_q == SERVE1) ? m1_addr  : m0_addr;
        sel_wdata = (state_q == SERVE1) ? m1_wdata : m0_wdata;
        legal     = access_legal(sel_we, sel_op, sel_addr[1:0]);

        dm_A     = 32'd0;
        dm_WD    = 32'd0;
        dm_op    = 3'd0;
        dm_wr    = 1'b0;
        m0_ready = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = 32'd0;
        m1_ready = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = 32'd0;

        if (state_q == SERVE0 || state_q == SERVE1) begin
            dm_A  = sel_addr;
            dm_WD = sel_wdata;
            dm_op = sel_op;
            dm_wr = sel_we && legal;
        end

        if (state_q == SERVE0) begin
            m0_ready = 1'b1;
            m0_err   = !legal;
            m0_rdata = legal ? dm_rdata : 32'd0;
        end

        if (state_q == SERVE1) begin
            m1_ready = 1'b1;
            m1_err   = !legal;
            m1_rdata = legal ? dm_rdata : 32'd0;
        end
    end

endmodule
